// File: rtl/fpga_input_ctrl.sv
// -----------------------------------------------------------------------------
// fpga_input_ctrl
//
// Front-end for the board's user inputs. Two raw push-buttons (load, step) are
// synchronized, debounced and turned into one-cycle strobes for the processor's
// current-instruction register. The 16 slide switches are synchronized and
// snapshotted as the manually entered instruction on every accepted load press.
// Accepted step presses are counted for display.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive disagreeing synchronized samples needed to
//                    accept a new button level (>= 2; 1_000_000 on the board)
//   CNT_W            width of step_count
//
// Ports
//   clk             system clock, all logic on the rising edge
//   reset           asynchronous, active-low; clears every register at once
//   btn_load        raw load button (asynchronous, bouncing)
//   btn_step        raw step button (asynchronous, bouncing)
//   sw[15:0]        raw slide switches (asynchronous)
//   halt            processor halted (synchronous); presses are dropped
//   pulse4          one-cycle load strobe, inst_from_fpga valid with it
//   pulse5          one-cycle step strobe (fetch from instruction memory)
//   inst_from_fpga  switch snapshot taken with the last pulse4
//   step_count      number of pulse5 strobes issued, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module fpga_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_load,
  input  logic             btn_step,
  input  logic [15:0]      sw,
  input  logic             halt,
  output logic             pulse4,
  output logic             pulse5,
  output logic [15:0]      inst_from_fpga,
  output logic [CNT_W-1:0] step_count
);

  // The debounce counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int              DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Button bit positions in the packed button vectors.
  localparam int BTN_LOAD = 0;
  localparam int BTN_STEP = 1;

  // Two-flop synchronizer stages; only the _p1 copies are used downstream.
  logic [1:0]      btn_p0;
  logic [1:0]      btn_p1;
  logic [15:0]     sw_p0;
  logic [15:0]     sw_p1;

  // Debounced levels, their one-cycle-delayed copies and run-length counters.
  logic [1:0]      stable;
  logic [1:0]      stable_d;
  logic [DB_W-1:0] db_cnt [2];

  logic [1:0]      rise;
  logic            pending;

  // Modulo-2^CNT_W increment of the displayed step count.
  function automatic logic [CNT_W-1:0] count_wrap(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] one;
    one        = '0;
    one[0]     = 1'b1;
    count_wrap = c + one;
  endfunction

  // Next value of a run-length counter that is still below its limit.
  function automatic logic [DB_W-1:0] db_inc(input logic [DB_W-1:0] c);
    logic [DB_W-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    db_inc = c + one;
  endfunction

  // ---- stage p0/p1: metastability synchronizers ----------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_p0 <= '0;
      btn_p1 <= '0;
      sw_p0  <= '0;
      sw_p1  <= '0;
    end else begin
      btn_p0 <= {btn_step, btn_load};
      btn_p1 <= btn_p0;
      sw_p0  <= sw;
      sw_p1  <= sw_p0;
    end
  end

  // ---- debounce: accept a level after DEBOUNCE_CYCLES disagreeing samples --
  // Any agreeing sample clears the run, so bursts shorter than the window
  // never reach the stable level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable   <= '0;
      stable_d <= '0;
      for (int b = 0; b < 2; b++) begin
        db_cnt[b] <= '0;
      end
    end else begin
      stable_d <= stable;
      for (int b = 0; b < 2; b++) begin
        if (btn_p1[b] == stable[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          stable[b] <= btn_p1[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_inc(db_cnt[b]);
        end
      end
    end
  end

  // Press edges only; releases are ignored.
  assign rise = stable & ~stable_d;

  // ---- strobe generation and arbitration -----------------------------------
  // Load has priority. A step press that collides with a load press (or any
  // step press arriving while one is already deferred) is folded into a
  // single deferred step issued on the next non-load cycle. Halt drops both
  // fresh and deferred presses so nothing is replayed when it lifts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse4         <= 1'b0;
      pulse5         <= 1'b0;
      pending        <= 1'b0;
      inst_from_fpga <= '0;
      step_count     <= '0;
    end else begin
      pulse4 <= 1'b0;
      pulse5 <= 1'b0;
      if (halt) begin
        pending <= 1'b0;
      end else if (rise[BTN_LOAD]) begin
        pulse4         <= 1'b1;
        inst_from_fpga <= sw_p1;
        pending        <= pending | rise[BTN_STEP];
      end else if (pending || rise[BTN_STEP]) begin
        pulse5     <= 1'b1;
        step_count <= count_wrap(step_count);
        pending    <= 1'b0;
      end
    end
  end

endmodule
